// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

    function automatic logic [63:0] min_value(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between a requester and the divider.
interface seq_divider_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // A guard bit above the partial remainder turns the borrow into the fit test.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, optional two's-complement
// mode (quotient truncates toward zero, remainder follows the dividend's sign).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    seq_divider_if.slave bus
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(min_value(WIDTH));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             zero_q, zero_d;
    logic             ovf_case_q, ovf_case_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             dvd_neg, dvs_neg, dvs_zero, ovf_case;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, q_mag, r_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (shf_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // MIN's magnitude is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    always_comb begin
        dvd_neg  = SIGNED && bus.dividend[WIDTH-1];
        dvs_neg  = SIGNED && bus.divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
        dvs_zero = (bus.divisor == '0);
        ovf_case = SIGNED && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
        q_mag    = {shf_q[WIDTH-2:0], step_bit};
        r_mag    = step_rem[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        shf_d      = shf_q;
        dvs_d      = dvs_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        zero_d     = zero_q;
        ovf_case_d = ovf_case_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        quo_d      = quo_q;
        rmd_d      = rmd_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d    = ITER;
                    ready_d    = 1'b0;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    sign_a_d   = dvd_neg;
                    sign_b_d   = dvs_neg;
                    zero_d     = dvs_zero;
                    ovf_case_d = ovf_case;
                    shf_d      = dvs_zero ? bus.dividend : dvd_mag;
                    dvs_d      = dvs_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                end
            end

            // A zero divisor spends a single cycle here so done lands one edge after accept.
            ITER: begin
                if (zero_q) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    quo_d   = '1;
                    rmd_d   = shf_q;
                    dbz_d   = 1'b1;
                end else begin
                    rem_d = step_rem;
                    shf_d = q_mag;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        quo_d   = (sign_a_q ^ sign_b_q) ? -q_mag : q_mag;
                        rmd_d   = sign_a_q ? -r_mag : r_mag;
                        ovf_d   = ovf_case_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            shf_q      <= '0;
            dvs_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            zero_q     <= 1'b0;
            ovf_case_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rmd_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            shf_q      <= shf_d;
            dvs_q      <= dvs_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            zero_q     <= zero_d;
            ovf_case_q <= ovf_case_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 10-bit unsigned/signed instances driven by a vector table,
// hand sequences and random operands; 4-bit instances swept exhaustively back-to-back.
module tb_seq_divider;

    logic       clock;
    logic       reset;
    logic       start_u10, start_s10, start4;
    logic [9:0] a10, b10;
    logic [3:0] a4, b4;
    int         total, bad;

    typedef struct {
        bit sgn;
        int a;
        int b;
        int q;
        int r;
        int dz;
        int ov;
        int lat;
    } vec_t;

    localparam int NV = 13;
    vec_t  tbl[NV];
    int    pairs[256];
    int    lat, q, r, dz, ov, dn, rd, eq, er, edz, eov, dcount, j, tmp, ai, bi;
    bit    sgn;
    string tag;

    seq_divider_if #(.WIDTH(10)) if_u10();
    seq_divider_if #(.WIDTH(10)) if_s10();
    seq_divider_if #(.WIDTH(4))  if_u4();
    seq_divider_if #(.WIDTH(4))  if_s4();

    assign if_u10.start    = start_u10;
    assign if_u10.dividend = a10;
    assign if_u10.divisor  = b10;
    assign if_s10.start    = start_s10;
    assign if_s10.dividend = a10;
    assign if_s10.divisor  = b10;
    assign if_u4.start     = start4;
    assign if_u4.dividend  = a4;
    assign if_u4.divisor   = b4;
    assign if_s4.start     = start4;
    assign if_s4.dividend  = a4;
    assign if_s4.divisor   = b4;

    seq_divider #(.WIDTH(10), .SIGNED(1'b0)) dut_u10 (.clock(clock), .reset(reset), .bus(if_u10));
    seq_divider #(.WIDTH(10), .SIGNED(1'b1)) dut_s10 (.clock(clock), .reset(reset), .bus(if_s10));
    seq_divider #(.WIDTH(4),  .SIGNED(1'b0)) dut_u4  (.clock(clock), .reset(reset), .bus(if_u4));
    seq_divider #(.WIDTH(4),  .SIGNED(1'b1)) dut_s4  (.clock(clock), .reset(reset), .bus(if_s4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer division on the operands' numeric values.
    function automatic void refDiv(input int w, input bit sm, input int a_raw, input int b_raw,
                                   output int rq, output int rr, output int rdz, output int rov);
        int mask, a, b, half;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        a    = a_raw;
        b    = b_raw;
        rdz  = 0;
        rov  = 0;
        if (b == 0) begin
            rq  = mask;
            rr  = a_raw;
            rdz = 1;
        end else begin
            if (sm) begin
                if (a >= half) a -= (1 << w);
                if (b >= half) b -= (1 << w);
            end
            if (sm && a == -half && b == -1) begin
                rov = 1;
                rq  = half;
                rr  = 0;
            end else begin
                rq = a / b;
                rr = a % b;
            end
            rq &= mask;
            rr &= mask;
        end
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sm, input int a, input int b);
        a10 = 10'(a);
        b10 = 10'(b);
        if (sm) start_s10 = 1'b1;
        else    start_u10 = 1'b1;
    endtask

    task automatic waitDone(input bit sm, input int poke_at, output int l);
        l = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) begin
                start_u10 = 1'b0;
                start_s10 = 1'b0;
            end
            if (k == poke_at) begin
                a10 = 10'd50;
                b10 = 10'd5;
                if (sm) start_s10 = 1'b1;
                else    start_u10 = 1'b1;
            end
            if (k == poke_at + 1) begin
                start_u10 = 1'b0;
                start_s10 = 1'b0;
            end
            if ((sm ? if_s10.done : if_u10.done) == 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic get10(input bit sm, output int gq, output int gr, output int gdz,
                         output int gov, output int gdn, output int grd);
        if (sm) begin
            gq = int'(if_s10.quotient);  gr = int'(if_s10.remainder);
            gdz = int'(if_s10.div_by_zero); gov = int'(if_s10.overflow);
            gdn = int'(if_s10.done);     grd = int'(if_s10.ready);
        end else begin
            gq = int'(if_u10.quotient);  gr = int'(if_u10.remainder);
            gdz = int'(if_u10.div_by_zero); gov = int'(if_u10.overflow);
            gdn = int'(if_u10.done);     grd = int'(if_u10.ready);
        end
    endtask

    task automatic check10(input string t, input bit sm, input int xq, input int xr,
                           input int xdz, input int xov);
        int gq, gr, gdz, gov, gdn, grd;
        get10(sm, gq, gr, gdz, gov, gdn, grd);
        checkOutput({t, "_q"}, gq, xq);
        checkOutput({t, "_r"}, gr, xr);
        checkOutput({t, "_dz"}, gdz, xdz);
        checkOutput({t, "_ov"}, gov, xov);
        checkOutput({t, "_ready"}, grd, 1);
    endtask

    task automatic checkReset(input string t);
        int gq, gr, gdz, gov, gdn, grd;
        for (int m = 0; m < 2; m++) begin
            get10(bit'(m), gq, gr, gdz, gov, gdn, grd);
            checkOutput($sformatf("%s_m%0d_ready", t, m), grd, 1);
            checkOutput($sformatf("%s_m%0d_done", t, m), gdn, 0);
            checkOutput($sformatf("%s_m%0d_q", t, m), gq, 0);
            checkOutput($sformatf("%s_m%0d_r", t, m), gr, 0);
            checkOutput($sformatf("%s_m%0d_dz", t, m), gdz, 0);
            checkOutput($sformatf("%s_m%0d_ov", t, m), gov, 0);
        end
        checkOutput({t, "_w4_q"}, int'(if_u4.quotient), 0);
        checkOutput({t, "_w4_ready"}, int'(if_s4.ready), 1);
    endtask

    initial begin
        tbl[0]  = '{0, 1000,    7,  142,    6, 0, 0, 10};
        tbl[1]  = '{0,    5,    0, 1023,    5, 1, 0,  1};
        tbl[2]  = '{0, 1023,    1, 1023,    0, 0, 0, 10};
        tbl[3]  = '{0,  100,   10,   10,    0, 0, 0, 10};
        tbl[4]  = '{0,    0,    3,    0,    0, 0, 0, 10};
        tbl[5]  = '{0,    6, 1023,    0,    6, 0, 0, 10};
        tbl[6]  = '{0, 1023, 1023,    1,    0, 0, 0, 10};
        tbl[7]  = '{1, 1017,    2, 1021, 1023, 0, 0, 10};
        tbl[8]  = '{1,    7, 1022, 1021,    1, 0, 0, 10};
        tbl[9]  = '{1,  512, 1023,  512,    0, 0, 1, 10};
        tbl[10] = '{1,    5,    0, 1023,    5, 1, 0,  1};
        tbl[11] = '{1,  512,    1,  512,    0, 0, 0, 10};
        tbl[12] = '{1,  511,  512,    0,  511, 0, 0, 10};

        total = 0;
        bad   = 0;
        reset = 1'b0;
        start_u10 = 1'b0; start_s10 = 1'b0; start4 = 1'b0;
        a10 = '0; b10 = '0; a4 = '0; b4 = '0;
        #1 reset = 1'b1;
        @(negedge clock);
        checkReset("rst");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            applyStimulus(tbl[i].sgn, tbl[i].a, tbl[i].b);
            waitDone(tbl[i].sgn, -1, lat);
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, "_lat"}, lat, tbl[i].lat);
            check10(tag, tbl[i].sgn, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);
            @(negedge clock);
            get10(tbl[i].sgn, q, r, dz, ov, dn, rd);
            checkOutput({tag, "_pulse"}, dn, 0);
        end

        $display("[TB] start pulsed during ITER must be ignored");
        @(negedge clock);
        applyStimulus(0, 1000, 7);
        waitDone(0, 3, lat);
        checkOutput("busy_lat", lat, 10);
        check10("busy", 0, 142, 6, 0, 0);

        $display("[TB] back-to-back starts held through DONE");
        @(negedge clock);
        applyStimulus(0, 1000, 7);
        waitDone(0, -1, lat);
        checkOutput("b2b0_lat", lat, 10);
        applyStimulus(0, 200, 3);
        waitDone(0, -1, lat);
        checkOutput("b2b1_spacing", lat + 1, 11);
        check10("b2b1", 0, 66, 2, 0, 0);
        applyStimulus(0, 9, 0);
        waitDone(0, -1, lat);
        checkOutput("b2b2_spacing", lat + 1, 2);
        check10("b2b2", 0, 1023, 9, 1, 0);
        applyStimulus(0, 1023, 1);
        waitDone(0, -1, lat);
        checkOutput("b2b3_lat", lat, 10);
        check10("b2b3", 0, 1023, 0, 0, 0);

        $display("[TB] asynchronous reset in the middle of ITER");
        @(negedge clock);
        applyStimulus(0, 1000, 7);
        @(negedge clock);
        start_u10 = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 checkReset("midrst");
        @(negedge clock);
        reset  = 1'b0;
        dcount = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (if_u10.done) dcount++;
        end
        checkOutput("midrst_no_done", dcount, 0);
        applyStimulus(0, 100, 10);
        waitDone(0, -1, lat);
        checkOutput("postrst_lat", lat, 10);
        check10("postrst", 0, 10, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            sgn = bit'(i & 1);
            ai  = int'($urandom_range(1023, 0));
            bi  = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(1023, 0));
            if (i % 15 == 1) begin
                ai = 512;
                bi = 1023;
            end
            @(negedge clock);
            applyStimulus(sgn, ai, bi);
            waitDone(sgn, -1, lat);
            refDiv(10, sgn, ai, bi, eq, er, edz, eov);
            tag = $sformatf("rnd%0d_m%0d_%0d_%0d", i, sgn, ai, bi);
            checkOutput({tag, "_lat"}, lat, (edz == 1) ? 1 : 10);
            check10(tag, sgn, eq, er, edz, eov);
        end

        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end

        // Start stays high so every result is followed immediately by the next accept.
        @(negedge clock);
        start4 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            ai  = pairs[p] >> 4;
            bi  = pairs[p] & 15;
            a4  = 4'(ai);
            b4  = 4'(bi);
            lat = -1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (if_u4.done) begin
                    lat = k;
                    break;
                end
            end
            tag = $sformatf("w4_%0d_%0d", ai, bi);
            refDiv(4, 0, ai, bi, eq, er, edz, eov);
            checkOutput({tag, "_spacing"}, lat + 1, (edz == 1) ? 2 : 5);
            checkOutput({tag, "_uq"}, int'(if_u4.quotient), eq);
            checkOutput({tag, "_ur"}, int'(if_u4.remainder), er);
            checkOutput({tag, "_udz"}, int'(if_u4.div_by_zero), edz);
            checkOutput({tag, "_uov"}, int'(if_u4.overflow), eov);
            refDiv(4, 1, ai, bi, eq, er, edz, eov);
            checkOutput({tag, "_sdone"}, int'(if_s4.done), 1);
            checkOutput({tag, "_sq"}, int'(if_s4.quotient), eq);
            checkOutput({tag, "_sr"}, int'(if_s4.remainder), er);
            checkOutput({tag, "_sdz"}, int'(if_s4.div_by_zero), edz);
            checkOutput({tag, "_sov"}, int'(if_s4.overflow), eov);
        end
        start4 = 1'b0;

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
